// File: rtl/mandel_engine_scheduler.sv
// Raster job scheduler: issues pixel coordinates round-robin to NUM_ENGINES engines,
// retires results in order onto an AXI4-Stream video output. Optional: CONTINUOUS_FRAMES_EN.
`timescale 1ns/1ps
module mandel_engine_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int X_SIZE      = 640,
  parameter int Y_SIZE      = 480,
  parameter int COORD_W     = 12
) (
  input  logic                      out_stream_aclk,
  input  logic                      periph_reset,
  input  logic                      start,
  output logic                      frame_busy,
  output logic                      frame_done,
  output logic [NUM_ENGINES-1:0]    job_valid,
  input  logic [NUM_ENGINES-1:0]    job_ready,
  output logic [COORD_W-1:0]        job_x,
  output logic [COORD_W-1:0]        job_y,
  input  logic [NUM_ENGINES-1:0]    res_valid,
  output logic [NUM_ENGINES-1:0]    res_ready,
  input  logic [NUM_ENGINES*32-1:0] res_data,
  output logic [31:0]               out_stream_tdata,
  output logic [3:0]                out_stream_tkeep,
  output logic                      out_stream_tlast,
  output logic                      out_stream_tuser,
  output logic                      out_stream_tvalid,
  input  logic                      out_stream_tready
);
  localparam int PW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [PW-1:0]      LAST_PTR = PW'(NUM_ENGINES - 1);
  localparam logic [COORD_W-1:0] LAST_X   = COORD_W'(X_SIZE - 1);
  localparam logic [COORD_W-1:0] LAST_Y   = COORD_W'(Y_SIZE - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                 state_r, state_s;
  logic [PW-1:0]          issue_ptr_r, retire_ptr_r;
  logic [COORD_W-1:0]     ix_r, iy_r, rx_r, ry_r;
  logic [NUM_ENGINES-1:0] busy_r;
  logic [31:0]            tdata_r;
  logic                   tlast_r, tuser_r, tvalid_r, end_frame_r, frame_busy_r;
  logic [NUM_ENGINES-1:0] job_valid_s, res_ready_s, issue_mask_s, retire_mask_s;
  logic                   start_frame_s, issue_hs_s, retire_hs_s, out_hs_s;
  logic                   last_issue_s, frame_done_s;

  // Offer/accept one-hot vectors and handshake decode
  always_comb begin
    job_valid_s = '0;
    res_ready_s = '0;
    if (state_r == RUN && !busy_r[issue_ptr_r]) begin
      job_valid_s[issue_ptr_r] = 1'b1;
    end else begin
      job_valid_s = '0;
    end
    if (busy_r[retire_ptr_r] && (!tvalid_r || out_stream_tready)) begin
      res_ready_s[retire_ptr_r] = 1'b1;
    end else begin
      res_ready_s = '0;
    end
    issue_mask_s  = job_valid_s & job_ready;
    retire_mask_s = res_ready_s & res_valid;
    issue_hs_s    = |issue_mask_s;
    retire_hs_s   = |retire_mask_s;
    out_hs_s      = tvalid_r && out_stream_tready;
    frame_done_s  = out_hs_s && end_frame_r;
    last_issue_s  = issue_hs_s && (ix_r == LAST_X) && (iy_r == LAST_Y);
    start_frame_s = (state_r == IDLE) && start;
  end

  // Frame FSM next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
`ifdef CONTINUOUS_FRAMES_EN
        state_s = RUN;
`else
        if (last_issue_s) state_s = DRAIN;
        else              state_s = RUN;
`endif
      end
      DRAIN: begin
        if (frame_done_s) state_s = IDLE;
        else              state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // Frame FSM state register
  always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
    if (periph_reset) state_r <= IDLE;
    else              state_r <= state_s;
  end

  // Issue/retire pointers, raster counters and engine occupancy
  always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      issue_ptr_r  <= '0;
      retire_ptr_r <= '0;
      ix_r <= '0; iy_r <= '0; rx_r <= '0; ry_r <= '0;
      busy_r <= '0;
    end else if (start_frame_s) begin
      issue_ptr_r  <= '0;
      retire_ptr_r <= '0;
      ix_r <= '0; iy_r <= '0; rx_r <= '0; ry_r <= '0;
      busy_r <= '0;
    end else begin
      // An engine cannot be both offered (busy=0) and retired (busy=1) in one cycle
      busy_r <= (busy_r | issue_mask_s) & ~retire_mask_s;
      if (issue_hs_s) begin
        issue_ptr_r <= (issue_ptr_r == LAST_PTR) ? '0 : issue_ptr_r + 1'b1;
        if (ix_r == LAST_X) begin
          ix_r <= '0;
          iy_r <= (iy_r == LAST_Y) ? '0 : iy_r + 1'b1;
        end else begin
          ix_r <= ix_r + 1'b1;
        end
      end
      if (retire_hs_s) begin
        retire_ptr_r <= (retire_ptr_r == LAST_PTR) ? '0 : retire_ptr_r + 1'b1;
        if (rx_r == LAST_X) begin
          rx_r <= '0;
          ry_r <= (ry_r == LAST_Y) ? '0 : ry_r + 1'b1;
        end else begin
          rx_r <= rx_r + 1'b1;
        end
      end
    end
  end

  // Stream output register, loaded on retire and held while stalled
  always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      tdata_r <= 32'd0; tlast_r <= 1'b0; tuser_r <= 1'b0;
      tvalid_r <= 1'b0; end_frame_r <= 1'b0;
    end else if (retire_hs_s) begin
      tdata_r     <= res_data[32*int'(retire_ptr_r) +: 32];
      tlast_r     <= (rx_r == LAST_X);
      tuser_r     <= (rx_r == '0) && (ry_r == '0);
      end_frame_r <= (rx_r == LAST_X) && (ry_r == LAST_Y);
      tvalid_r    <= 1'b1;
    end else if (out_hs_s) begin
      tvalid_r <= 1'b0;
    end else begin
      tvalid_r <= tvalid_r;
    end
  end

  // Frame busy flag
  always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      frame_busy_r <= 1'b0;
    end else if (start_frame_s) begin
      frame_busy_r <= 1'b1;
`ifndef CONTINUOUS_FRAMES_EN
    end else if (frame_done_s) begin
      frame_busy_r <= 1'b0;
`endif
    end else begin
      frame_busy_r <= frame_busy_r;
    end
  end

  assign job_valid         = job_valid_s;
  assign res_ready         = res_ready_s;
  assign job_x             = ix_r;
  assign job_y             = iy_r;
  assign frame_busy        = frame_busy_r;
  assign frame_done        = frame_done_s;
  assign out_stream_tdata  = tdata_r;
  assign out_stream_tkeep  = 4'hF;
  assign out_stream_tlast  = tlast_r;
  assign out_stream_tuser  = tuser_r;
  assign out_stream_tvalid = tvalid_r;
endmodule

// File: tb/tb_mandel_engine_scheduler.sv
// Directed scoreboard bench for mandel_engine_scheduler (4x2 frame, 2 engines).
`timescale 1ns/1ps
module tb_mandel_engine_scheduler;
  localparam int N = 2;
  localparam int XS = 4;
  localparam int YS = 2;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst, start, tready;
  logic frame_busy, frame_done, tlast, tuser, tvalid;
  logic [N-1:0] job_valid, job_ready, res_valid, res_ready;
  logic [CW-1:0] job_x, job_y;
  logic [N*32-1:0] res_data;
  logic [31:0] tdata;
  logic [3:0] tkeep;

  always #5 clk = ~clk;

  mandel_engine_scheduler #(.NUM_ENGINES(N), .X_SIZE(XS), .Y_SIZE(YS), .COORD_W(CW)) dut (
    .out_stream_aclk(clk), .periph_reset(rst), .start(start),
    .frame_busy(frame_busy), .frame_done(frame_done),
    .job_valid(job_valid), .job_ready(job_ready), .job_x(job_x), .job_y(job_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .out_stream_tdata(tdata), .out_stream_tkeep(tkeep), .out_stream_tlast(tlast),
    .out_stream_tuser(tuser), .out_stream_tvalid(tvalid), .out_stream_tready(tready));

  // engine model: one job slot each, result = {y, x} in byte fields after lat cycles
  logic [N-1:0] eb;
  int cnt [N];
  int lat [N];
  logic [31:0] ed [N];
  assign job_ready = ~eb;
  assign res_data  = {ed[1], ed[0]};
  always_comb for (int i = 0; i < N; i++) res_valid[i] = eb[i] && (cnt[i] == 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eb <= '0;
      for (int i = 0; i < N; i++) begin cnt[i] <= 0; ed[i] <= 32'd0; end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (eb[i]) begin
          if (res_valid[i] && res_ready[i]) eb[i] <= 1'b0;
          else if (cnt[i] != 0) cnt[i] <= cnt[i] - 1;
        end else if (job_valid[i]) begin
          eb[i]  <= 1'b1;
          cnt[i] <= lat[i];
          ed[i]  <= {16'd0, job_y[7:0], job_x[7:0]};
        end
      end
    end
  end

  typedef struct packed {logic [31:0] d; logic last; logic user; logic eof;} beat_t;
  beat_t sb [$];
  int compared = 0;
  int mismatched = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int held0 = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame();
    for (int y = 0; y < YS; y++)
      for (int x = 0; x < XS; x++) begin
        beat_t b;
        b.d    = (y << 8) | x;
        b.last = (x == XS - 1);
        b.user = (x == 0) && (y == 0);
        b.eof  = (x == XS - 1) && (y == YS - 1);
        sb.push_back(b);
      end
  endtask

  // stream monitor: pop expected beat on every handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid[0] && !res_ready[0] && eb[1]) held0++;
      if (frame_done) done_cnt++;
      if (tvalid && tready) begin
        beat_t e;
        beat_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("tdata", 64'(tdata), 64'(e.d));
          check("tlast", 64'(tlast), 64'(e.last));
          check("tuser", 64'(tuser), 64'(e.user));
          check("frame_done", 64'(frame_done), 64'(e.eof));
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("first_job_valid", 64'(job_valid), 64'd1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 2000) begin @(negedge clk); n++; end
    check("done_timeout", 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic check_reset_outputs();
    check("reset_stream", 64'({tvalid, tlast, tuser, tdata, tkeep}), 64'({3'b000, 32'd0, 4'hF}));
    check("reset_ctrl", 64'({frame_busy, frame_done, job_valid, res_ready, job_x, job_y}), 64'd0);
  endtask

  task automatic run_frame(input int l0, input int l1, input bit dup, input bit stall);
    int b0 = beat_cnt;
    int d0 = done_cnt;
    lat[0] = l0; lat[1] = l1;
    push_frame();
    pulse_start();
    if (dup) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    if (stall) begin
      for (int k = 0; k < 200; k++) begin
        @(posedge clk); #1;
        if (tvalid && beat_cnt >= b0 + 2) break;
      end
      tready = 1'b0;
      repeat (5) begin
        @(negedge clk);
        check("stall_tvalid", 64'(tvalid), 64'd1);
        check("stall_res_ready", 64'(res_ready), 64'd0);
        if (sb.size() > 0) begin
          check("stall_tdata", 64'(tdata), 64'(sb[0].d));
          check("stall_flags", 64'({tlast, tuser}), 64'({sb[0].last, sb[0].user}));
        end else begin
          check("stall_sb_empty", 64'd1, 64'd0);
        end
      end
      @(posedge clk); #1 tready = 1'b1;
    end
    wait_done(d0 + 1);
    @(negedge clk);
    check("beats_per_frame", 64'(beat_cnt - b0), 64'(XS * YS));
    check("done_per_frame", 64'(done_cnt - d0), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("frame_busy_fall", 64'(frame_busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tready = 1'b1;
    lat[0] = 3; lat[1] = 3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rst = 1'b0;
`ifdef CONTINUOUS_FRAMES_EN
    push_frame();
    push_frame();
    pulse_start();
    wait_done(2);
    check("cont_done_cnt", 64'(done_cnt), 64'd2);
    check("cont_frame_busy", 64'(frame_busy), 64'd1);
    check("cont_beats", 64'(beat_cnt), 64'(2 * XS * YS));
`else
    run_frame(3, 3, 1'b0, 1'b0);
    held0 = 0;
    run_frame(1, 10, 1'b0, 1'b0);
    check("engine0_held", 64'(held0 > 0), 64'd1);
    run_frame(3, 3, 1'b0, 1'b1);
    run_frame(3, 3, 1'b1, 1'b0);
    // reset mid-frame after three beats, then a clean frame
    begin
      int b0 = beat_cnt;
      int n = 0;
      lat[0] = 3; lat[1] = 3;
      push_frame();
      pulse_start();
      while (beat_cnt < b0 + 3 && n < 500) begin @(negedge clk); n++; end
      check("reset_wait", 64'(beat_cnt >= b0 + 3), 64'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check_reset_outputs();
      sb.delete();
      @(posedge clk); #1 rst = 1'b0;
      run_frame(3, 3, 1'b0, 1'b0);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
